// File: rtl/ann_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : ann_coef_loader
// Description : Upstream feeder for the ANN core. Streams 16-bit words over a
//               valid/ready handshake into an image buffer (NUM_INPUTS words)
//               and a weight buffer (NUM_INPUTS x NUM_HIDDEN words, row-major,
//               input-major). Both buffers are presented as flat buses.
//               image_weights_loaded pulses for one cycle when a load
//               completes. The ANN can then request a weights-only reload
//               or a full image+weights reload, or end with done_processing.
//
//               Optional build macro ANN_LOADER_CHECKSUM_EN adds a CHECK
//               state. CHECK accepts one trailing checksum word, which is the
//               sum modulo 2^DATA_W of all words in the load. A mismatch sets
//               the sticky load_error and restarts at LOAD_IMAGE with no pulse.
//               Without the macro, load_error is tied low.
//
// Ports       : clk                  - system clock, rising edge
//               n_rst                - synchronous active-low reset
//               data_in/data_valid   - streamed word and its qualifier
//               data_ready           - loader accepts a word (state only)
//               image_flat           - image[i] at [i*DATA_W +: DATA_W]
//               weights_flat         - weights[i][j] at
//                                      [(i*NUM_HIDDEN+j)*DATA_W +: DATA_W]
//               image_weights_loaded - one-cycle completion pulse
//               request_coef         - reload request from the ANN
//               coef_select          - 1 = weights only, 0 = image+weights
//               done_processing      - ANN finished, restart full load
//               busy                 - high while loading
//               load_error           - sticky checksum error
//
// Revision    : 1.0 - initial release
// ============================================================================
module ann_coef_loader #(
    parameter int NUM_INPUTS = 64,
    parameter int NUM_HIDDEN = 16,
    parameter int DATA_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic [DATA_W-1:0]                     data_in,
    input  logic                                  data_valid,
    output logic                                  data_ready,
    output logic [NUM_INPUTS*DATA_W-1:0]          image_flat,
    output logic [NUM_INPUTS*NUM_HIDDEN*DATA_W-1:0] weights_flat,
    output logic                                  image_weights_loaded,
    input  logic                                  request_coef,
    input  logic                                  coef_select,
    input  logic                                  done_processing,
    output logic                                  busy,
    output logic                                  load_error
);

    localparam int NUM_W  = NUM_INPUTS * NUM_HIDDEN;
    localparam int CNT_W  = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int IMG_AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic [CNT_W-1:0] C_IMG_LAST = CNT_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] C_WGT_LAST = CNT_W'(NUM_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_LOAD_IMAGE   = 3'd0,
        S_LOAD_WEIGHTS = 3'd1,
        S_CHECK        = 3'd2,
        S_ISSUE        = 3'd3,
        S_WAIT_ANN     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_image   [NUM_INPUTS];
    logic [DATA_W-1:0] r_weights [NUM_W];
    logic              w_accept;

    assign w_accept = data_valid && data_ready;

`ifdef ANN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    // Marks that the next accepted data word starts a new load.
    logic              r_first;
    logic              r_err;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_LOAD_IMAGE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next               = r_state;
        data_ready           = 1'b0;
        busy                 = 1'b0;
        image_weights_loaded = 1'b0;
        case (r_state)
            S_LOAD_IMAGE: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && (r_cnt == C_IMG_LAST)) begin
                    w_next = S_LOAD_WEIGHTS;
                end
            end
            S_LOAD_WEIGHTS: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && (r_cnt == C_WGT_LAST)) begin
`ifdef ANN_LOADER_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_ISSUE;
`endif
                end
            end
            S_CHECK: begin
                data_ready = 1'b1;
                busy       = 1'b1;
`ifdef ANN_LOADER_CHECKSUM_EN
                if (w_accept) begin
                    w_next = (data_in == r_sum) ? S_ISSUE : S_LOAD_IMAGE;
                end
`else
                w_next = S_LOAD_IMAGE;
`endif
            end
            S_ISSUE: begin
                image_weights_loaded = 1'b1;
                w_next               = S_WAIT_ANN;
            end
            S_WAIT_ANN: begin
                // done_processing outranks any coefficient request.
                if (done_processing) begin
                    w_next = S_LOAD_IMAGE;
                end else if (request_coef && coef_select) begin
                    w_next = S_LOAD_WEIGHTS;
                end else if (request_coef) begin
                    w_next = S_LOAD_IMAGE;
                end
            end
            default: begin
                w_next = S_LOAD_IMAGE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word counter and buffers. The counter is left at zero after each
    // phase, so a weights-only reload starts at weights[0][0].
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_image[i] <= '0;
            end
            for (int i = 0; i < NUM_W; i++) begin
                r_weights[i] <= '0;
            end
        end else if (w_accept) begin
            case (r_state)
                S_LOAD_IMAGE: begin
                    r_image[r_cnt[IMG_AW-1:0]] <= data_in;
                    r_cnt <= (r_cnt == C_IMG_LAST) ? '0 : r_cnt + C_CNT_ONE;
                end
                S_LOAD_WEIGHTS: begin
                    r_weights[r_cnt] <= data_in;
                    r_cnt <= (r_cnt == C_WGT_LAST) ? '0 : r_cnt + C_CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ANN_LOADER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running checksum. The first data word of a load reseeds the sum and
    // clears any previous error. The checksum word itself is not summed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sum   <= '0;
            r_first <= 1'b1;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_CHECK) begin
                r_first <= 1'b1;
                if (data_in != r_sum) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_sum   <= r_first ? data_in : r_sum + data_in;
                r_first <= 1'b0;
                if (r_first) begin
                    r_err <= 1'b0;
                end
            end
        end
    end

    assign load_error = r_err;
`else
    assign load_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Flat bus views of the buffers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_img
            assign image_flat[gi*DATA_W +: DATA_W] = r_image[gi];
        end
        for (gi = 0; gi < NUM_W; gi++) begin : g_wgt
            assign weights_flat[gi*DATA_W +: DATA_W] = r_weights[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/ann_coef_loader.md
Name: ann_coef_loader

Overview:
- Upstream feeder for the ANN core.
- Accepts a stream of 16-bit words over a valid/ready handshake and fills an image buffer (64 words) and a weight buffer (64x16 words).
- Presents both buffers as flat parallel buses and pulses image_weights_loaded when a load is complete.
- Services the ANN's request_coef/coef_select handshake by reloading either weights only or a full image+weights set, until done_processing.

Parameters:
- NUM_INPUTS, 64, number of image pixels / input nodes.
- NUM_HIDDEN, 16, number of weights per input node.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  synchronous active-low reset, sampled on rising edge of clk.
- data_in  in  DATA_W  streamed word.
- data_valid  in  1  data_in valid.
- data_ready  out  1  loader can accept a word this cycle.
- image_flat  out  NUM_INPUTS*DATA_W  image[i] at bits [i*DATA_W +: DATA_W].
- weights_flat  out  NUM_INPUTS*NUM_HIDDEN*DATA_W  weights[i][j] at bits [(i*NUM_HIDDEN+j)*DATA_W +: DATA_W].
- image_weights_loaded  out  1  one-cycle pulse: buffers complete and stable.
- request_coef  in  1  ANN requests a new coefficient load.
- coef_select  in  1  qualifies request_coef: 1 = weights only, 0 = image+weights.
- done_processing  in  1  ANN finished; loader returns to start.
- busy  out  1  high in any LOAD state.
- load_error  out  1  sticky error flag.

Behaviour:
- Reset (n_rst low at a rising edge):
  - State goes to LOAD_IMAGE; word counter = 0.
  - Buffers cleared to 0.
  - image_weights_loaded = 0, load_error = 0, data_ready = 1, busy = 1.
  - Reset asserted mid-load discards the partial load; the next accepted word is image[0].
- Transfer rule: a word is accepted on a rising edge where data_valid && data_ready. data_ready is combinational from state only, never from data_valid.
- States:
  - LOAD_IMAGE: data_ready = 1. Accepted word k is written to image[k]. After word NUM_INPUTS-1 is accepted, clear the counter and go to LOAD_WEIGHTS.
  - LOAD_WEIGHTS: data_ready = 1. Accepted word k is written to weights[k/NUM_HIDDEN][k%NUM_HIDDEN] (row-major, input-major). After word NUM_INPUTS*NUM_HIDDEN-1 is accepted, go to ISSUE (or CHECK when the optional feature is enabled).
  - ISSUE: data_ready = 0, image_weights_loaded = 1 for exactly this one cycle, then go to WAIT_ANN.
  - WAIT_ANN: data_ready = 0, busy = 0.
    - done_processing -> LOAD_IMAGE.
    - Otherwise request_coef && coef_select -> LOAD_WEIGHTS; the image is kept.
    - Otherwise request_coef && !coef_select -> LOAD_IMAGE.
    - done_processing has priority over request_coef in the same cycle.
- Latency: the pulse is asserted in the cycle immediately after the edge that accepts the last word, so the last word to pulse is 1 cycle.
- request_coef and done_processing are ignored outside WAIT_ANN. No queuing: a request during a load is lost.
- data_valid low stalls the counter indefinitely; there is no timeout.
- Buffer contents change only on accepted words. Partially reloaded buffers are visible during reload; the ANN must not sample them before the pulse.
- load_error is set only by the optional check. It clears on reset or on acceptance of the first word of the next load.
- Full-load transfer counts: 64 + 1024 = 1088 words. Weights-only reload: 1024 words.

Optional Feature:
- Macro: ANN_LOADER_CHECKSUM_EN.
- When defined:
  - A CHECK state follows LOAD_WEIGHTS with data_ready = 1. It accepts one extra word: the expected sum modulo 2^DATA_W of all words accepted in this load (image words plus weight words for a full load, weight words only for a reload).
  - Running sum is cleared at load start.
  - Match -> ISSUE.
  - Mismatch -> load_error = 1, no pulse, state -> LOAD_IMAGE.
- When undefined: no CHECK state, no checksum word, load_error is tied to 0.

Test Plan:
- Reset, then stream image[i] = i and weights[i][j] = 16*i + j -> image_weights_loaded pulses exactly once, 1 cycle after word 1087; image_flat[15:0] = 0; weights_flat bits [(5*16+3)*16 +: 16] = 83; data_ready = 0 in WAIT_ANN.
- Toggle data_valid every other cycle during the full load -> the pulse occurs only after 1088 accepted words; no word is written twice.
- In WAIT_ANN: request_coef = 1, coef_select = 1, stream 1024 words of 0xAAAA -> image unchanged, all weights = 0xAAAA, one pulse.
- In WAIT_ANN: request_coef = 1, done_processing = 1 in the same cycle -> next state is LOAD_IMAGE, next accepted word goes to image[0].
- Assert n_rst low after 30 image words, then stream a full load -> buffers hold only the new data; exactly one pulse.
- With ANN_LOADER_CHECKSUM_EN: all-ones load with a correct checksum (1088*0xFFFF mod 2^16 = 0xFBC0) -> pulse. The same load with checksum 0x0000 -> load_error = 1, no pulse, data_ready = 1.
